ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send direction of the existing keyboard receive path (kb_interface).
- Sends one command byte to the keyboard, e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-drain PS/2 clock and data lines and checks the device ACK bit.
- Runs in the clk65MHz domain. Asserts rx_inhibit so kb_interface ignores the bus while a transfer is in flight.

Parameters:
- INHIBIT_CYCLES, 7800: cycles the host holds ps2_clk low before the request (120 us at 65 MHz).
- TIMEOUT_CYCLES, 975000: maximum cycles between consecutive device clock falling edges (15 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples required before a line level is accepted.

Ports:
- clk  in  1  system clock, clk65MHz
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  block idle; a transfer is accepted when tx_valid && tx_ready
- ps2_clk_in  in  1  PS/2 clock line level (asynchronous)
- ps2_data_in  in  1  PS/2 data line level (asynchronous)
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release (high-Z)
- ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release
- rx_inhibit  out  1  high whenever state is not IDLE
- tx_done  out  1  one-cycle pulse at end of a transfer
- tx_ack_ok  out  1  valid while tx_done is high; 1 = device ACK seen
- tx_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values:
  - tx_ready=1.
  - ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_done, tx_ack_ok, tx_error all 0.
  - State=IDLE; all counters 0.
- Reset asserted mid-transfer releases both lines immediately (asynchronous) and aborts the transfer with no tx_done/tx_error pulse.
- Line inputs pass through a 2-flop synchronizer and then the FILTER_LEN filter. clk_fall is a one-cycle pulse on a filtered 1->0 transition.
- Accept (IDLE, tx_valid=1):
  - Latch tx_data.
  - Parity = ~^tx_data (odd parity).
  - bit_cnt=0. Go to INHIBIT; tx_ready drops the next cycle.
  - tx_valid while not IDLE is ignored.
- INHIBIT:
  - clk_drive_low=1 for INHIBIT_CYCLES cycles.
  - data_drive_low=1 from the last INHIBIT cycle on (this is the start bit).
  - Then go to REQ: clk released, data still driven low; timeout counter cleared.
- Shift (REQ/DATA), on each clk_fall:
  - bit_cnt 0..7: data_drive_low = ~byte[bit_cnt], LSB first.
  - bit_cnt 8: data_drive_low = ~parity.
  - bit_cnt 9: data_drive_low=0 (stop bit; data released).
  - bit_cnt increments on every clk_fall.
- ACK: on the clk_fall with bit_cnt==10, sample filtered data; ack = (data==0).
- WAIT_IDLE:
  - Wait until filtered clk=1 and data=1.
  - Then pulse tx_done with tx_ack_ok=ack and return to IDLE.
  - tx_ready=1 in the same cycle the state reads IDLE.
- NACK (data high at ACK) is not an error: tx_done pulses with tx_ack_ok=0.
- Timeout:
  - In REQ, DATA, ACK and WAIT_IDLE, a counter clears on each clk_fall.
  - Reaching TIMEOUT_CYCLES → release both lines, pulse tx_error (tx_done not pulsed), go to IDLE.
- tx_done and tx_error never pulse in the same cycle.
- States: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
- The inhibit counter needs ceil(log2(INHIBIT_CYCLES+1)) bits; the timeout counter sized the same way from TIMEOUT_CYCLES.

Decomposition:
- Shared package ps2_pkg holds:
  - state encodings;
  - frame constants: 11 bit periods, ACK index 10;
  - command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RSP_ACK=8'hFA.
- Sub-module ps2_line_filter:
  - synchronizer, FILTER_LEN filter and fall-edge detector;
  - instantiated twice, once for clk and once for data;
  - reusable by kb_interface.

Test Plan (bench params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, FILTER_LEN=2; device model clocks at 40-cycle period):
- Send 0xED, device ACKs → clk_drive_low high for exactly 20 cycles; device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done=1 with tx_ack_ok=1; tx_ready=1 afterwards.
- Send 0xF4, device NACKs (data high at edge 11) → parity bit 0 observed; tx_done pulse with tx_ack_ok=0; no tx_error.
- Send 0xFF, device stops clocking after bit 3 → tx_error pulses 200 cycles after the last clk_fall; both drives 0; state IDLE; no tx_done.
- tx_valid held high during a transfer with tx_data changing to 0x00 → device still receives the originally latched byte; exactly one tx_done.
- Reset asserted during DATA at bit 5 → both drive outputs 0 in the same cycle, rx_inhibit=0, tx_ready=1; a following 0xF4 transfer completes normally.
- 1-cycle glitch on ps2_clk_in during DATA → no extra bit shifted; received frame still correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the keyboard
// receive path: transmitter state encoding, frame geometry, command bytes and
// the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_DATA,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_t;

   // One host-to-device frame is 11 device clock periods:
   // start, 8 data bits, parity, stop, then the device ACK bit.
   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_ACK_INDEX  = 10;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one asynchronous PS/2 line (clock or data).
// A 2-flop synchronizer is followed by a glitch filter that only accepts a
// new level after FILTER_LEN consecutive equal samples; fall pulses for one
// cycle when the accepted level goes 1 -> 0.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset (line assumed idle high)
//   line_in in   raw line level
//   level   out  filtered line level
//   fall    out  one-cycle pulse on a filtered falling edge
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             fall_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         level_reg <= 1'b1;
         fall_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= line_in;
         sync2_reg <= sync1_reg;
         fall_reg  <= 1'b0;
         if (sync2_reg == level_reg) begin
            // Any return to the accepted level restarts the run.
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg;
            fall_reg  <= level_reg;   // old level 1 means this is a fall
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign level = level_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte:
// inhibits the bus, requests to send, shifts out data/parity/stop on device
// clock falls, samples the device ACK and waits for the bus to go idle.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   tx_data, tx_valid     command byte and request; accepted when tx_ready
//   tx_ready              block idle
//   ps2_clk_in/data_in    raw PS/2 line levels
//   ps2_clk_drive_low     1 = pull PS/2 clock low
//   ps2_data_drive_low    1 = pull PS/2 data low
//   rx_inhibit            transfer in flight; receiver must ignore the bus
//   tx_done, tx_ack_ok    end-of-transfer pulse and ACK result
//   tx_error              pulse on device clock timeout
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 7800,
   parameter int TIMEOUT_CYCLES = 975000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       rx_inhibit,
   output logic       tx_done,
   output logic       tx_ack_ok,
   output logic       tx_error
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BIT_W = $clog2(PS2_FRAME_BITS + 1);

   logic clk_level, clk_fall, data_level, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk(clk), .reset(reset), .line_in(ps2_clk_in),
      .level(clk_level), .fall(clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk(clk), .reset(reset), .line_in(ps2_data_in),
      .level(data_level), .fall(data_fall_unused)
   );

   ps2_tx_state_t state_reg, state_next;
   logic [7:0]    byte_reg, byte_next;
   logic          parity_reg, parity_next;
   logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [INH_W-1:0] inhibit_cnt_reg, inhibit_cnt_next;
   logic [TMO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic          data_drive_reg, data_drive_next;
   logic          ack_reg, ack_next;
   logic          tx_done_reg, tx_done_next;
   logic          tx_ack_ok_reg, tx_ack_ok_next;
   logic          tx_error_reg, tx_error_next;
   logic          inhibit_last;

   assign inhibit_last = (inhibit_cnt_reg == INH_W'(INHIBIT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         byte_reg        <= '0;
         parity_reg      <= 1'b0;
         bit_cnt_reg     <= '0;
         inhibit_cnt_reg <= '0;
         timeout_cnt_reg <= '0;
         data_drive_reg  <= 1'b0;
         ack_reg         <= 1'b0;
         tx_done_reg     <= 1'b0;
         tx_ack_ok_reg   <= 1'b0;
         tx_error_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         byte_reg        <= byte_next;
         parity_reg      <= parity_next;
         bit_cnt_reg     <= bit_cnt_next;
         inhibit_cnt_reg <= inhibit_cnt_next;
         timeout_cnt_reg <= timeout_cnt_next;
         data_drive_reg  <= data_drive_next;
         ack_reg         <= ack_next;
         tx_done_reg     <= tx_done_next;
         tx_ack_ok_reg   <= tx_ack_ok_next;
         tx_error_reg    <= tx_error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      byte_next        = byte_reg;
      parity_next      = parity_reg;
      bit_cnt_next     = bit_cnt_reg;
      inhibit_cnt_next = inhibit_cnt_reg;
      timeout_cnt_next = timeout_cnt_reg;
      data_drive_next  = data_drive_reg;
      ack_next         = ack_reg;
      tx_done_next     = 1'b0;
      tx_ack_ok_next   = 1'b0;
      tx_error_next    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            data_drive_next = 1'b0;
            if (tx_valid) begin
               byte_next        = tx_data;
               parity_next      = odd_parity(tx_data);
               bit_cnt_next     = '0;
               inhibit_cnt_next = '0;
               state_next       = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inhibit_last) begin
               data_drive_next  = 1'b1;   // start bit held through REQ
               timeout_cnt_next = '0;
               state_next       = ST_REQ;
            end else begin
               inhibit_cnt_next = inhibit_cnt_reg + 1'b1;
            end
         end
         ST_REQ, ST_DATA: begin
            if (clk_fall) begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
               state_next   = ST_DATA;
               if (bit_cnt_reg < BIT_W'(8)) begin
                  data_drive_next = ~byte_reg[bit_cnt_reg[2:0]];
               end else if (bit_cnt_reg == BIT_W'(8)) begin
                  data_drive_next = ~parity_reg;
               end else begin
                  data_drive_next = 1'b0;   // stop bit: line released
                  state_next      = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (clk_fall && bit_cnt_reg == BIT_W'(PS2_ACK_INDEX)) begin
               ack_next     = ~data_level;
               bit_cnt_next = bit_cnt_reg + 1'b1;
               state_next   = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_level && data_level) begin
               tx_done_next   = 1'b1;
               tx_ack_ok_next = ack_reg;
               state_next     = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Device clock watchdog; overrides any completion in the same cycle so
      // tx_done and tx_error can never pulse together.
      if (state_reg inside {ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE}) begin
         if (clk_fall) begin
            timeout_cnt_next = '0;
         end else if (timeout_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_cnt_next = '0;
            data_drive_next  = 1'b0;
            tx_done_next     = 1'b0;
            tx_ack_ok_next   = 1'b0;
            tx_error_next    = 1'b1;
            state_next       = ST_IDLE;
         end else begin
            timeout_cnt_next = timeout_cnt_reg + 1'b1;
         end
      end
   end

   // Drive outputs decode straight from asynchronously reset registers so a
   // reset releases both lines without waiting for a clock edge.
   assign tx_ready           = (state_reg == ST_IDLE);
   assign rx_inhibit         = (state_reg != ST_IDLE);
   assign ps2_clk_drive_low  = (state_reg == ST_INHIBIT);
   assign ps2_data_drive_low = data_drive_reg | ((state_reg == ST_INHIBIT) & inhibit_last);
   assign tx_done            = tx_done_reg;
   assign tx_ack_ok          = tx_ack_ok_reg;
   assign tx_error           = tx_error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_drive_low, ps2_data_drive_low;
   logic       rx_inhibit, tx_done, tx_ack_ok, tx_error;

   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic glitch       = 1'b0;

   // Open-drain bus: a line is low if anyone pulls it low.
   assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low | glitch);
   assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200), .FILTER_LEN(2)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
      .rx_inhibit(rx_inhibit), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok),
      .tx_error(tx_error)
   );

   typedef struct packed {
      logic is_err;
      logic ack;
   } evt_t;

   evt_t        exp_evt_q[$];
   logic [10:0] exp_frame_q[$];   // {stop, parity, byte, start}

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int inh_run  = 0;
   int inh_len  = 0;
   int last_fall_cyc = 0;

   // Hand-computed frames: bit0 = start, bits 8:1 = byte LSB first, parity, stop.
   localparam logic [10:0] FRAME_ED = 11'b1_1_11101101_0;
   localparam logic [10:0] FRAME_F4 = 11'b1_0_11110100_0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Scoreboard monitor: pops an expected event on every tx_done/tx_error.
   initial begin
      evt_t e;
      forever begin
         @(negedge clk);
         if (ps2_clk_drive_low) inh_run++;
         else if (inh_run != 0) begin
            inh_len = inh_run;
            inh_run = 0;
         end
         if (tx_done && tx_error) check("done_and_error_together", 1, 0);
         if (tx_done || tx_error) begin
            if (exp_evt_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got done=%0b error=%0b expected none", tx_done, tx_error);
            end else begin
               e = exp_evt_q.pop_front();
               check("event_is_error", tx_error, e.is_err);
               if (!e.is_err) check("event_ack_ok", tx_ack_ok, e.ack);
               else check("error_lines_released",
                          {ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_ready}, 4'b0001);
            end
         end
      end
   end

   task automatic start_tx(input logic [7:0] b, input bit hold_valid);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      if (hold_valid) tx_data = 8'h00;
      else tx_valid = 1'b0;
   endtask

   // Device model: waits for the host request, then produces n_falls clock
   // pulses (40-cycle period), sampling data late in each high phase.
   task automatic dev_frame(input int n_falls, input bit nack, input bit do_glitch);
      logic [10:0] frame;
      logic [10:0] exp;
      int g;
      frame = '0;
      g = 0;
      while (!ps2_clk_drive_low && g < 100) begin @(negedge clk); g++; end
      g = 0;
      while (ps2_clk_drive_low && g < 100) begin @(negedge clk); g++; end
      repeat (10) @(negedge clk);
      check("inhibit_len", inh_len, 20);
      check("request_data_low", ps2_data_in, 1'b0);
      for (int k = 0; k < n_falls; k++) begin
         frame[k] = ps2_data_in;
         if (k == 10 && !nack) begin
            dev_data_low = 1'b1;
            repeat (2) @(negedge clk);
         end
         dev_clk_low   = 1'b1;
         last_fall_cyc = cyc;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         if (do_glitch && k == 3) begin
            repeat (8) @(negedge clk);
            glitch = 1'b1;
            @(negedge clk);
            glitch = 1'b0;
            repeat (11) @(negedge clk);
         end else begin
            repeat (20) @(negedge clk);
         end
      end
      dev_data_low = 1'b0;
      if (n_falls == 11) begin
         if (exp_frame_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame: got %0h expected no frame", frame);
         end else begin
            exp = exp_frame_q.pop_front();
            check("device_frame", frame, exp);
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while (exp_evt_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
      check({name, "_event_seen"}, exp_evt_q.size(), 0);
      @(negedge clk);
      check({name, "_ready_after"}, {tx_ready, rx_inhibit}, 2'b10);
   endtask

   initial begin
      int g;
      int d;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {tx_ready, ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_done, tx_ack_ok, tx_error},
            7'b1000000);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // 0xED with device ACK.
      exp_frame_q.push_back(FRAME_ED);
      exp_evt_q.push_back('{is_err: 1'b0, ack: 1'b1});
      start_tx(PS2_CMD_SET_LEDS, 1'b0);
      check("busy_after_accept", {tx_ready, rx_inhibit}, 2'b01);
      dev_frame(11, 1'b0, 1'b0);
      wait_drain("ed_ack");

      // 0xF4 with device NACK.
      exp_frame_q.push_back(FRAME_F4);
      exp_evt_q.push_back('{is_err: 1'b0, ack: 1'b0});
      start_tx(PS2_CMD_ENABLE, 1'b0);
      dev_frame(11, 1'b1, 1'b0);
      wait_drain("f4_nack");

      // 0xFF, device stops clocking after bit 3.
      exp_evt_q.push_back('{is_err: 1'b1, ack: 1'b0});
      start_tx(PS2_CMD_RESET, 1'b0);
      dev_frame(4, 1'b0, 1'b0);
      g = 0;
      while (!tx_error && g < 400) begin @(negedge clk); g++; end
      d = cyc - last_fall_cyc;
      check("timeout_error_seen", tx_error, 1'b1);
      check("timeout_delay_200_to_210", (d >= 200 && d <= 210), 1'b1);
      check("timeout_idle", {ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_ready}, 4'b0001);
      wait_drain("ff_timeout");

      // tx_valid held with tx_data changed: original byte must go out once.
      exp_frame_q.push_back(FRAME_ED);
      exp_evt_q.push_back('{is_err: 1'b0, ack: 1'b1});
      start_tx(PS2_CMD_SET_LEDS, 1'b1);
      dev_frame(11, 1'b0, 1'b0);
      tx_valid = 1'b0;
      wait_drain("held_valid");
      repeat (30) @(negedge clk);
      check("held_valid_no_retrigger", {tx_ready, rx_inhibit, ps2_clk_drive_low}, 3'b100);

      // Reset during DATA after bit 4 has been driven (bit_cnt = 5).
      start_tx(PS2_CMD_SET_LEDS, 1'b0);
      dev_frame(5, 1'b0, 1'b0);
      check("pre_reset_bit4_driven", {ps2_data_drive_low, rx_inhibit}, 2'b11);
      #2 reset = 1'b1;
      #1 check("reset_mid_transfer",
               {ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_ready}, 4'b0001);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      exp_frame_q.push_back(FRAME_F4);
      exp_evt_q.push_back('{is_err: 1'b0, ack: 1'b1});
      start_tx(PS2_CMD_ENABLE, 1'b0);
      dev_frame(11, 1'b0, 1'b0);
      wait_drain("after_reset_f4");

      // One-cycle glitch on the clock line during a high phase.
      exp_frame_q.push_back(FRAME_ED);
      exp_evt_q.push_back('{is_err: 1'b0, ack: 1'b1});
      start_tx(PS2_CMD_SET_LEDS, 1'b0);
      dev_frame(11, 1'b0, 1'b1);
      wait_drain("glitch");

      repeat (20) @(negedge clk);
      check("frames_all_consumed", exp_frame_q.size(), 0);
      check("events_all_consumed", exp_evt_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
